// File: rtl/ssb_demodulator.sv
// SSB demodulator: buffers I samples behind the Hilbert group delay, then forms I -/+ Q per sideband.
// Build option: define SSB_DEMOD_SAT_EN for full-gain saturating output (default is half gain).
module ssb_demodulator #(
   parameter int DELAY      = 15,
   parameter int FIFO_DEPTH = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] i_data_i,
   input  logic        i_valid_i,
   input  logic [15:0] q_data_i,
   input  logic        q_valid_i,
   input  logic        usb_i,
   output logic [15:0] audio_o,
   output logic        valid_o,
   output logic        err_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(DELAY + 1);
   localparam logic [WW-1:0] DELAY_W = WW'(DELAY);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(FIFO_DEPTH);

   logic [15:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic [WW-1:0]      warm_cnt;
   logic               warm_done, pop_req, fifo_empty, fifo_full;
   logic               do_pop, do_push, underflow, overflow;
   logic signed [16:0] i_ext, q_ext, sum;
   logic [15:0]        audio_nxt;

   assign warm_done  = (warm_cnt == DELAY_W);
   assign pop_req    = q_valid_i && warm_done;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH_W);
   // Underflow looks only at stored samples; a same-cycle push cannot be popped.
   assign do_pop     = pop_req && !fifo_empty;
   assign underflow  = pop_req && fifo_empty;
   assign do_push    = i_valid_i && (!fifo_full || do_pop);
   assign overflow   = i_valid_i && fifo_full && !do_pop;

   assign i_ext = {mem[rd_ptr][15], mem[rd_ptr]};
   assign q_ext = {q_data_i[15], q_data_i};
   assign sum   = usb_i ? (i_ext - q_ext) : (i_ext + q_ext);

`ifdef SSB_DEMOD_SAT_EN
   always_comb begin
      // NOTE: default assigned first so no latch is inferred on the untaken branch.
      audio_nxt = sum[15:0];
      if (sum[16] != sum[15])
         audio_nxt = sum[16] ? 16'h8000 : 16'h7fff;
   end
`else
   assign audio_nxt = 16'(sum >>> 1);
`endif

   // NOTE: sample storage has no reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push)
         mem[wr_ptr] <= i_data_i;
   end

   // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         warm_cnt <= '0;
         audio_o  <= '0;
         valid_o  <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (q_valid_i && !warm_done)
            warm_cnt <= warm_cnt + 1'b1;
         valid_o <= do_pop;
         if (do_pop)
            audio_o <= audio_nxt;
         if (overflow || underflow)
            err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ssb_demodulator.sv
// Self-checking bench for ssb_demodulator: spec vectors, corner sequences and random traffic
// against a queue-based reference model.
module tb_ssb_demodulator;

   localparam int DELAY      = 15;
   localparam int FIFO_DEPTH = 32;
`ifdef SSB_DEMOD_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk_i, rst_i;
   logic [15:0] i_data_i, q_data_i, audio_o;
   logic        i_valid_i, q_valid_i, usb_i, valid_o, err_o;

   ssb_demodulator #(.DELAY(DELAY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_data_i (i_data_i),
      .i_valid_i(i_valid_i),
      .q_data_i (q_data_i),
      .q_valid_i(q_valid_i),
      .usb_i    (usb_i),
      .audio_o  (audio_o),
      .valid_o  (valid_o),
      .err_o    (err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int n_dut_valid = 0;

   // reference model state
   int fifo_q[$];
   int warm;
   bit m_err;
   bit m_valid;
   int m_audio;

   typedef struct {
      int i_d;
      int q_d;
      bit usb;
      int exp;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ref_audio(input int i, input int q, input bit usb);
      int s;
      s = usb ? (i - q) : (i + q);
      if (SAT) begin
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
         return s;
      end
      return s >>> 1;
   endfunction

   task automatic cycle(input bit iv, input int id, input bit qv, input int qd, input bit usb);
      bit pop_req;
      i_valid_i = iv;
      i_data_i  = 16'(id);
      q_valid_i = qv;
      q_data_i  = 16'(qd);
      usb_i     = usb;
      pop_req   = qv && (warm == DELAY);
      m_valid   = 1'b0;
      if (pop_req) begin
         if (fifo_q.size() > 0) begin
            m_audio = ref_audio(fifo_q.pop_front(), qd, usb);
            m_valid = 1'b1;
         end else
            m_err = 1'b1;
      end
      if (iv) begin
         if (fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(id);
         else m_err = 1'b1;
      end
      if (qv && warm < DELAY) warm++;
      @(posedge clk_i);
      #1;
      if (valid_o) n_dut_valid++;
      check("valid", int'(valid_o), int'(m_valid));
      check("audio", int'($signed(audio_o)), m_audio);
      check("err", int'(err_o), int'(m_err));
      i_valid_i = 1'b0;
      q_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i     = 1'b1;
      i_valid_i = 1'b1;
      q_valid_i = 1'b1;
      i_data_i  = 16'h1234;
      q_data_i  = 16'h0042;
      #2;
      check("rst_audio_now", int'(audio_o), 0);
      check("rst_valid_now", int'(valid_o), 0);
      check("rst_err_now", int'(err_o), 0);
      @(posedge clk_i);
      #1;
      check("rst_held_valid", int'(valid_o), 0);
      rst_i     = 1'b0;
      i_valid_i = 1'b0;
      q_valid_i = 1'b0;
      fifo_q.delete();
      warm    = 0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_audio = 0;
   endtask

   initial begin
      vecs[0] = '{1000, 300, 1'b1, SAT ? 700 : 350};
      vecs[1] = '{1000, 300, 1'b0, SAT ? 1300 : 650};
      vecs[2] = '{30000, -10000, 1'b1, SAT ? 32767 : 20000};
      vecs[3] = '{-30000, 10000, 1'b1, SAT ? -32768 : -20000};
      vecs[4] = '{32767, -32768, 1'b1, 32767};
      vecs[5] = '{-32768, 32767, 1'b1, -32768};
      vecs[6] = '{-1, 0, 1'b1, -1};
      vecs[7] = '{0, 0, 1'b0, 0};

      rst_i = 1'b0; i_valid_i = 1'b0; q_valid_i = 1'b0;
      i_data_i = '0; q_data_i = '0; usb_i = 1'b0;
      #1;
      do_reset();

      // 20 I then 20 Q: exactly 5 outputs, first pairs with I sample 0
      for (int k = 0; k < 20; k++) cycle(1'b1, 100 * k + 2, 1'b0, 0, 1'b0);
      n_dut_valid = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, 0, 1'b1, 0, 1'b1);
         if (k == DELAY) check("first_pair_i0", int'($signed(audio_o)), SAT ? 2 : 1);
      end
      check("warmup_output_count", n_dut_valid, 5);
      check("warmup_err", int'(err_o), 0);

      // spec vectors on a warmed-up, empty FIFO
      do_reset();
      for (int k = 0; k < DELAY; k++) cycle(1'b0, 0, 1'b1, 0, 1'b0);
      for (int v = 0; v < 8; v++) begin
         cycle(1'b1, vecs[v].i_d, 1'b0, 0, 1'b0);
         cycle(1'b0, 0, 1'b1, vecs[v].q_d, vecs[v].usb);
         check($sformatf("vec%0d_audio", v), int'($signed(audio_o)), vecs[v].exp);
         check($sformatf("vec%0d_valid", v), int'(valid_o), 1);
      end

      // underflow: no output, audio held, err set and sticky
      cycle(1'b0, 0, 1'b1, 5, 1'b1);
      check("underflow_valid", int'(valid_o), 0);
      check("underflow_err", int'(err_o), 1);
      cycle(1'b1, 400, 1'b0, 0, 1'b0);
      cycle(1'b0, 0, 1'b1, 100, 1'b1);
      check("err_sticky", int'(err_o), 1);

      // overflow: 33rd sample dropped, FIFO drains in order afterwards
      do_reset();
      for (int k = 0; k < 33; k++) cycle(1'b1, 3 * k - 40, 1'b0, 0, 1'b0);
      check("overflow_err", int'(err_o), 1);
      for (int k = 0; k < DELAY; k++) cycle(1'b0, 0, 1'b1, 0, 1'b0);
      for (int k = 0; k < 33; k++) cycle(1'b0, 0, 1'b1, k, k[0]);
      check("overflow_drop_last", int'(valid_o), 0);

      // full FIFO with simultaneous push and pop, then drain across pointer wrap
      do_reset();
      for (int k = 0; k < FIFO_DEPTH; k++) cycle(1'b1, 1000 + k, 1'b0, 0, 1'b0);
      for (int k = 0; k < DELAY; k++) cycle(1'b0, 0, 1'b1, 0, 1'b0);
      cycle(1'b1, 5555, 1'b1, 0, 1'b1);
      check("full_pushpop_head", int'($signed(audio_o)), SAT ? 1000 : 500);
      check("full_pushpop_err", int'(err_o), 0);
      for (int k = 0; k < FIFO_DEPTH; k++) cycle(1'b0, 0, 1'b1, -7, 1'b0);
      check("full_tail_new", int'($signed(audio_o)), ref_audio(5555, -7, 1'b0));
      check("full_drain_err", int'(err_o), 0);

      // mid-stream reset with 10 samples buffered
      do_reset();
      for (int k = 0; k < 12; k++) cycle(1'b1, 2000 + k, 1'b0, 0, 1'b0);
      for (int k = 0; k < DELAY + 2; k++) cycle(1'b0, 0, 1'b1, 11, 1'b1);
      check("pre_reset_audio_nonzero", int'(audio_o != 16'd0), 1);
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b1, -500 - k, 1'b0, 0, 1'b0);
      n_dut_valid = 0;
      for (int k = 0; k < DELAY; k++) cycle(1'b0, 0, 1'b1, 9, 1'b0);
      check("rewarm_no_output", n_dut_valid, 0);
      cycle(1'b0, 0, 1'b1, 9, 1'b0);
      check("rewarm_first_out", int'($signed(audio_o)), ref_audio(-500, 9, 1'b0));

      // randomized traffic against the model, with one reset mid-run
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         cycle($urandom_range(0, 99) < 48, int'($urandom_range(0, 65535)) - 32768,
               $urandom_range(0, 99) < 45, int'($urandom_range(0, 65535)) - 32768,
               1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
